// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// default data/address widths.
package ram_arbiter_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_AWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: with both requesting, the port
// that did not win last time is chosen.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU (port 0) and DMA (port 1) accesses onto a single-port RAM
// with a req/ack handshake and round-robin arbitration.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_load,
  output logic [WIDTH-1:0]  ram_in,
  input  logic [WIDTH-1:0]  ram_out,
  output logic              busy,
  output logic              gnt,
  output state_t            dbg_state
);

  // Handshake: a requester raises reqN with we/addr/wdata valid and holds it
  // until ackN; the request is sampled only in IDLE, ackN pulses for one cycle,
  // and a req still high in the following IDLE cycle is a new transaction.

  state_t              r_state;
  state_t              w_next_state;
  logic                r_gnt;
  logic                r_we;
  logic [AWIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [WIDTH-1:0]    r_rdata0;
  logic [WIDTH-1:0]    r_rdata1;
  logic                w_valid;
  logic                w_winner;
  logic [WIDTH-1:0]    w_capture;

  rr_pick2 u_pick (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_last   (r_gnt),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A write reports back the value it stored so rdata always reflects the
  // last completed access on that port.
  assign w_capture = r_we ? r_wdata : ram_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_valid) begin
        r_gnt   <= w_winner;
        r_we    <= w_winner ? we1    : we0;
        r_addr  <= w_winner ? addr1  : addr0;
        r_wdata <= w_winner ? wdata1 : wdata0;
      end
      if (r_state == ACCESS) begin
        if (r_gnt) r_rdata1 <= w_capture;
        else       r_rdata0 <= w_capture;
      end
    end
  end

  // Reset gates the write strobe combinationally so an aborted ACCESS never
  // commits to the RAM.
  assign ram_load    = (r_state == ACCESS) & r_we & ~reset;
  assign ram_address = r_addr;
  assign ram_in      = r_wdata;
  assign ack0        = (r_state == RESP) & ~r_gnt;
  assign ack1        = (r_state == RESP) & r_gnt;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign busy        = (r_state != IDLE);
  assign gnt         = r_gnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: external RAM, transaction-level reference model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] ram_address, ram_in, ram_out;
  logic        ram_load, busy, gnt;
  logic [1:0]  dbg_state;

  int n_compared = 0;
  int n_mismatch = 0;
  bit chk_en = 0;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_load(ram_load), .ram_in(ram_in),
    .ram_out(ram_out), .busy(busy), .gnt(gnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external RAM ----------------
  logic [15:0] ram_mem [0:65535];
  initial for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0;
  assign ram_out = ram_mem[ram_address];
  always @(posedge clk) if (ram_load) ram_mem[ram_address] <= ram_in;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time: winner latched at an IDLE edge, its RAM
  // cycle is the next cycle, its ack the cycle after that.
  int          cyc = 0;
  bit          m_active = 0;
  int          t_acc = 0;
  bit          t_we = 0;
  logic [15:0] t_addr = 0, t_wdata = 0;
  bit          m_gnt = 1;
  logic [15:0] m_rd [2];
  logic [15:0] m_mem [logic [15:0]];

  initial begin m_rd[0] = 0; m_rd[1] = 0; end

  always @(posedge clk) begin
    bit w;
    if (reset) begin
      m_active = 0; m_gnt = 1; m_rd[0] = 0; m_rd[1] = 0;
      t_we = 0; t_addr = 0; t_wdata = 0;
    end else if (m_active && cyc == t_acc) begin
      if (t_we) begin
        m_mem[t_addr] = t_wdata;
        m_rd[m_gnt]   = t_wdata;
      end else begin
        m_rd[m_gnt] = m_mem.exists(t_addr) ? m_mem[t_addr] : 16'h0;
      end
    end else if (m_active && cyc == t_acc + 1) begin
      m_active = 0;
    end else if (!m_active && (req0 || req1)) begin
      if (req0 && !req1)      w = 0;
      else if (req1 && !req0) w = 1;
      else                    w = !m_gnt;
      m_gnt   = w;
      t_we    = w ? we1 : we0;
      t_addr  = w ? addr1 : addr0;
      t_wdata = w ? wdata1 : wdata0;
      t_acc   = cyc + 1;
      m_active = 1;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit in_acc, in_resp;
    if (chk_en) begin
      in_acc  = m_active && cyc == t_acc;
      in_resp = m_active && cyc == t_acc + 1;
      chk("ack0", {31'b0, ack0}, {31'b0, in_resp && !m_gnt});
      chk("ack1", {31'b0, ack1}, {31'b0, in_resp && m_gnt});
      chk("busy", {31'b0, busy}, {31'b0, in_acc || in_resp});
      chk("gnt", {31'b0, gnt}, {31'b0, m_gnt});
      chk("ram_load", {31'b0, ram_load}, {31'b0, in_acc && t_we && !reset});
      chk("ram_address", {16'b0, ram_address}, {16'b0, t_addr});
      chk("ram_in", {16'b0, ram_in}, {16'b0, t_wdata});
      chk("rdata0", {16'b0, rdata0}, {16'b0, m_rd[0]});
      chk("rdata1", {16'b0, rdata1}, {16'b0, m_rd[1]});
      chk("state", {30'b0, dbg_state}, in_acc ? 32'd1 : (in_resp ? 32'd2 : 32'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit p, input logic we, input logic [15:0] a, input logic [15:0] d);
    if (!p) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Waits (bounded) for the port's ack; reports latency in negedges and how
  // many of those cycles had ram_load high.
  task automatic wait_ack(input bit p, output logic [15:0] rd, output int lat,
                          output int loads, output int ack_cyc);
    bit got = 0;
    lat = 0; loads = 0; rd = 16'hx; ack_cyc = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ram_load) loads++;
      if ((p ? ack1 : ack0) === 1'b1) begin
        got = 1; rd = p ? rdata1 : rdata0; ack_cyc = cyc;
      end
    end
    if (!got) chk(p ? "ack1_timeout" : "ack0_timeout", 0, 1);
  endtask

  task automatic end_req(input bit p);
    @(posedge clk); #1;
    if (!p) req0 = 0; else req1 = 0;
  endtask

  task automatic transact(input bit p, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat,
                          output int loads);
    int ac;
    start_req(p, we, a, d);
    wait_ack(p, rd, lat, loads, ac);
    end_req(p);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [15:0] rd0, rd1;
    int lat0, lat1, ld0, ld1, ac0, ac1, n;
    int ack_port[$];
    int ack_time[$];

    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 reset = 0;

    // reset then idle
    chk("lit_reset_gnt", {31'b0, gnt}, 1);
    chk("lit_reset_busy", {31'b0, busy}, 0);
    chk("lit_reset_rdata0", {16'b0, rdata0}, 0);
    chk("lit_reset_ram_address", {16'b0, ram_address}, 0);
    n = 0;
    repeat (10) begin @(negedge clk); if (ram_load) n++; end
    chk("lit_idle_loads", n, 0);

    // port 0 write then read
    @(posedge clk); #1;
    transact(0, 1, 16'd0, 16'd4321, rd0, lat0, ld0);
    chk("lit_wr_latency", lat0, 3);
    chk("lit_wr_loads", ld0, 1);
    transact(0, 0, 16'd0, 16'd0, rd0, lat0, ld0);
    chk("lit_rd_latency", lat0, 3);
    chk("lit_rd_loads", ld0, 0);
    chk("lit_rd_data", {16'b0, rd0}, 4321);

    // simultaneous writes after reset release: port 0 first
    pulse_reset();
    fork
      begin
        start_req(0, 1, 16'd4321, 16'd12345);
        wait_ack(0, rd0, lat0, ld0, ac0);
        end_req(0);
      end
      begin
        start_req(1, 1, 16'd7, 16'hFFFF);
        wait_ack(1, rd1, lat1, ld1, ac1);
        end_req(1);
      end
    join
    chk("lit_both_p0_latency", lat0, 3);
    chk("lit_both_gap", ac1 - ac0, 3);
    transact(0, 0, 16'd4321, 16'd0, rd0, lat0, ld0);
    chk("lit_both_rd0", {16'b0, rd0}, 12345);
    transact(1, 0, 16'd7, 16'd0, rd1, lat1, ld1);
    chk("lit_both_rd1", {16'b0, rd1}, 32'h0000FFFF);

    // both hold read req for 12 cycles: acks alternate every 3 cycles
    start_req(0, 0, 16'd4321, 16'd0);
    start_req(1, 0, 16'd7, 16'd0);
    repeat (12) begin
      @(negedge clk);
      if (ack0) begin ack_port.push_back(0); ack_time.push_back(cyc); end
      if (ack1) begin ack_port.push_back(1); ack_time.push_back(cyc); end
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    chk("lit_rr_count", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size(); i++) begin
      chk("lit_rr_order", ack_port[i], i % 2);
      if (i > 0) chk("lit_rr_spacing", ack_time[i] - ack_time[i-1], 3);
    end
    chk("lit_rr_rdata0", {16'b0, rdata0}, 12345);
    chk("lit_rr_rdata1", {16'b0, rdata1}, 32'h0000FFFF);

    // reset during ACCESS of a write: aborted, no ack
    @(posedge clk); #1;
    start_req(0, 1, 16'd5, 16'd999);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; req0 = 0;
    n = 0;
    repeat (5) begin @(negedge clk); if (ack0 || ack1) n++; end
    chk("lit_abort_acks", n, 0);
    @(posedge clk); #1;
    transact(0, 0, 16'd5, 16'd0, rd0, lat0, ld0);
    chk("lit_abort_rd", {16'b0, rd0}, 0);

    // address/data changed mid-transaction are ignored
    start_req(0, 1, 16'd9, 16'h55AA);
    @(posedge clk); #1 addr0 = 16'd10; wdata0 = 16'h1111;
    wait_ack(0, rd0, lat0, ld0, ac0);
    end_req(0);
    chk("lit_midchg_latency", lat0, 2);
    chk("lit_midchg_loads", ld0, 1);
    transact(0, 0, 16'd9, 16'd0, rd0, lat0, ld0);
    chk("lit_midchg_rd9", {16'b0, rd0}, 32'h000055AA);
    transact(0, 0, 16'd10, 16'd0, rd0, lat0, ld0);
    chk("lit_midchg_rd10", {16'b0, rd0}, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_compared);
    $fatal(1, "watchdog expired");
  end

endmodule
